// File: rtl/m6502_bus_monitor.sv
// Passive 6502 bus observer: logs opcode fetches to a FIFO, counts cycles/instructions and detects self-loop traps.
// Optional write logging is enabled by defining M6502_MONITOR_WRITE_LOG_EN.
module m6502_bus_monitor #(
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             sample_en,
   input  logic [15:0]      address,
   input  logic [7:0]       data,
   input  logic             rw,
   input  logic             sync,
   input  logic             enable,
   input  logic             clear,
   input  logic             rd_en,
   output logic [25:0]      rd_data,
   output logic             rd_valid,
   output logic             overflow,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] instr_count,
   output logic             trapped,
   output logic [15:0]      trap_pc
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int FILL_W = PTR_W + 1;
   localparam logic [FILL_W-1:0] DEPTH_C = FILL_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      WAIT_SYNC = 2'd0,
      RUN       = 2'd1,
      TRAPPED   = 2'd2
   } state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) return v;
      else    return v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   state_t             state_r;
   logic [15:0]        last_pc_r;
   logic               last_pc_valid_r;
   logic [CNT_W-1:0]   cycle_count_r;
   logic [CNT_W-1:0]   instr_count_r;
   logic               trapped_r;
   logic [15:0]        trap_pc_r;
   logic               overflow_r;
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [FILL_W-1:0]  fill_r;
   logic [25:0]        rd_data_r;
   logic [25:0]        mem_r [FIFO_DEPTH];

   logic               qual_s;
   logic               fetch_s;
   logic               push_s;
   logic               pop_s;
   logic               full_s;
   logic               accept_s;
   logic               drop_s;
   logic [25:0]        rec_s;
   logic [PTR_W-1:0]   rd_ptr_nxt_s;
   logic [FILL_W-1:0]  fill_nxt_s;
   logic [25:0]        head_nxt_s;

   // Qualify bus samples and decide what, if anything, enters the FIFO this cycle.
   always_comb begin
      qual_s  = sample_en & enable;
      fetch_s = qual_s & sync & rw;
      rec_s   = {2'b01, address, data};
      case (state_r)
         WAIT_SYNC: push_s = fetch_s;
         RUN:       push_s = fetch_s;
         default:   push_s = 1'b0;
      endcase
`ifdef M6502_MONITOR_WRITE_LOG_EN
      if ((state_r == RUN) && qual_s && !rw) begin
         push_s = 1'b1;
         rec_s  = {2'b10, address, data};
      end else begin
         push_s = push_s;
      end
`endif
      if (clear) begin
         push_s = 1'b0;
      end else begin
         push_s = push_s;
      end
      pop_s    = rd_en & (fill_r != {FILL_W{1'b0}}) & ~clear;
      full_s   = (fill_r == DEPTH_C);
      accept_s = push_s & (~full_s | pop_s);
      drop_s   = push_s & full_s & ~pop_s;
   end

   // Next head pointer/fill level; a record written into the slot that becomes head bypasses memory.
   always_comb begin
      rd_ptr_nxt_s = pop_s ? (rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1}) : rd_ptr_r;
      fill_nxt_s   = fill_r + FILL_W'(accept_s) - FILL_W'(pop_s);
      if (fill_nxt_s == {FILL_W{1'b0}}) begin
         head_nxt_s = 26'd0;
      end else if (accept_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
         head_nxt_s = rec_s;
      end else begin
         head_nxt_s = mem_r[rd_ptr_nxt_s];
      end
   end

   // Record storage.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         mem_r[wr_ptr_r] <= rec_s;
      end
   end

   // FIFO pointers, registered head and sticky overflow.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         fill_r     <= {FILL_W{1'b0}};
         rd_data_r  <= 26'd0;
         overflow_r <= 1'b0;
      end else if (clear) begin
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         fill_r     <= {FILL_W{1'b0}};
         rd_data_r  <= 26'd0;
         overflow_r <= 1'b0;
      end else begin
         if (accept_s) begin
            wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         rd_ptr_r  <= rd_ptr_nxt_s;
         fill_r    <= fill_nxt_s;
         rd_data_r <= head_nxt_s;
         if (drop_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // Monitor FSM: arms on the first fetch, counts while running, latches the first self-loop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r         <= WAIT_SYNC;
         last_pc_r       <= 16'h0000;
         last_pc_valid_r <= 1'b0;
         cycle_count_r   <= {CNT_W{1'b0}};
         instr_count_r   <= {CNT_W{1'b0}};
         trapped_r       <= 1'b0;
         trap_pc_r       <= 16'h0000;
      end else if (clear) begin
         state_r         <= WAIT_SYNC;
         last_pc_r       <= 16'h0000;
         last_pc_valid_r <= 1'b0;
         cycle_count_r   <= {CNT_W{1'b0}};
         instr_count_r   <= {CNT_W{1'b0}};
         trapped_r       <= 1'b0;
         trap_pc_r       <= 16'h0000;
      end else begin
         case (state_r)
            WAIT_SYNC: begin
               if (fetch_s) begin
                  state_r         <= RUN;
                  cycle_count_r   <= sat_inc(cycle_count_r);
                  instr_count_r   <= sat_inc(instr_count_r);
                  last_pc_r       <= address;
                  last_pc_valid_r <= 1'b1;
               end
            end
            RUN: begin
               if (qual_s) begin
                  cycle_count_r <= sat_inc(cycle_count_r);
               end
               if (fetch_s) begin
                  instr_count_r <= sat_inc(instr_count_r);
                  if (last_pc_valid_r && (address == last_pc_r)) begin
                     state_r   <= TRAPPED;
                     trapped_r <= 1'b1;
                     trap_pc_r <= address;
                  end else begin
                     last_pc_r       <= address;
                     last_pc_valid_r <= 1'b1;
                  end
               end
            end
            TRAPPED: state_r <= TRAPPED;
            default: state_r <= WAIT_SYNC;
         endcase
      end
   end

   assign rd_data     = rd_data_r;
   assign rd_valid    = (fill_r != {FILL_W{1'b0}});
   assign overflow    = overflow_r;
   assign cycle_count = cycle_count_r;
   assign instr_count = instr_count_r;
   assign trapped     = trapped_r;
   assign trap_pc     = trap_pc_r;

endmodule

// File: doc/m6502_bus_monitor.md
Name: m6502_bus_monitor

Overview:
- Passive bus observer, sits directly downstream of the M6502 core and consumes its `address`, `data`, `rw` and `sync` outputs.
- Logs every opcode fetch (address and opcode) into a record FIFO.
- Maintains cycle and instruction counters.
- Detects a self-loop trap (`JMP *`, `Bxx *`), the end/fail condition of functional test programs, so a bench can stop the simulation early.

Parameters:
- `FIFO_DEPTH`, 16, number of records; must be a power of two, ≥ 2.
- `CNT_W`, 32, width of the cycle and instruction counters.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `sample_en`  in  1  bus-valid strobe, one `clk` cycle per CPU bus cycle. Bus inputs are sampled only on a rising `clk` edge with `sample_en`=1.
- `address`  in  16  CPU address bus.
- `data`  in  8  CPU data bus.
- `rw`  in  1  1=read, 0=write.
- `sync`  in  1  opcode-fetch indicator.
- `enable`  in  1  0 freezes logging, counters and trap detection.
- `clear`  in  1  synchronous clear: empties FIFO, zeroes counters, drops overflow and trap, returns FSM to WAIT_SYNC.
- `rd_en`  in  1  pop one FIFO record.
- `rd_data`  out  26  head record: {type[1:0], addr[15:0], data[7:0]}.
- `rd_valid`  out  1  FIFO not empty.
- `overflow`  out  1  sticky; a record was dropped.
- `cycle_count`  out  `CNT_W`  sampled bus cycles.
- `instr_count`  out  `CNT_W`  opcode fetches.
- `trapped`  out  1  self-loop detected.
- `trap_pc`  out  16  address of the trapping opcode.

Behaviour:
- Reset (async, `reset_n`=0): FIFO empty, `rd_valid`=0, `rd_data`=0, `overflow`=0, both counters 0, `trapped`=0, `trap_pc`=0, FSM=WAIT_SYNC, `last_pc` valid flag cleared. `clear`=1 produces the same state on the next edge and has priority over all other inputs that cycle.
- Fetch: a qualified sample (`sample_en`=1 & `enable`=1) with `sync`=1 & `rw`=1.
- Record types: 2'b01 = opcode fetch, 2'b10 = write (optional feature only). 2'b00 and 2'b11 are never produced.
- FSM states:
  - WAIT_SYNC: counters frozen, nothing logged. First fetch → RUN; that fetch is counted and logged, and `last_pc`=`address`.
  - RUN:
    - Each qualified sample increments `cycle_count`.
    - Each fetch increments `instr_count` and pushes {01, `address`, `data`}.
    - If a fetch `address` equals `last_pc` (valid): → TRAPPED, `trapped`=1, `trap_pc`=`address`. The trapping fetch is still logged and counted.
    - Otherwise `last_pc` ← `address`.
  - TRAPPED: no pushes; counters frozen. Exit only via `clear` or reset.
- Counters saturate at all-ones; no wrap.
- FIFO:
  - Registered head, `rd_data` valid whenever `rd_valid`=1.
  - Pop on `rd_en` & `rd_valid`. `rd_en` when empty is ignored.
  - Push when full without a simultaneous pop: record dropped, `overflow` ← 1 (sticky).
  - Push and pop in the same cycle when full: both succeed, no drop.
  - Push and pop in the same cycle when empty: the record is accepted, `rd_valid`=1 next cycle.
  - Push-to-`rd_valid` latency: 1 `clk`.
  - Pointer wrap is modulo `FIFO_DEPTH`.
- `enable`=0: no state change except FIFO pops and `clear`.
- Reset mid-operation discards all records immediately (asynchronous).

Optional Feature:
- Macro: `M6502_MONITOR_WRITE_LOG_EN`.
- Defined: a qualified sample with `rw`=0 in RUN pushes {10, `address`, `data`}. Write samples neither advance `last_pc` nor affect trap detection. A write and a fetch can never coincide.
- Undefined: write cycles are never logged; `type` is always 01; `rd_data` width is unchanged.

Test Plan:
1. Reset, then fetches at 0x0000/0xA9, 0x0002/0xE8 → two records {01,0000,A9}, {01,0002,E8}; `instr_count`=2; `rd_valid` deasserts after two pops.
2. Fetches 0x0400, 0x0403, 0x0403 → `trapped`=1, `trap_pc`=0x0403, 3 records. Further fetches add no records and `instr_count` stays 3. `clear` → `trapped`=0, counters 0, FSM back in WAIT_SYNC.
3. `FIFO_DEPTH`=16: 17 distinct fetches with no pops → 16 records, `overflow`=1, first record popped is fetch #1. Repeat with a pop on the 17th push → no overflow.
4. 10 non-sync samples before the first fetch → `cycle_count`=0 until the fetch, then 1.
5. Assert `reset_n`=0 mid-stream with 5 records queued → `rd_valid`=0 and counters 0 before the next `clk` edge.
6. With `M6502_MONITOR_WRITE_LOG_EN`: STA to 0x0200 of 0x55 → record {10,0200,55}. Fetch 0x0010, write, fetch 0x0010 → trap at 0x0010. Without the macro, no type-10 records ever appear.
